// File: rtl/egress_switch_pkg.sv
// Shared constants and types for the egress switch: port/width defaults,
// arbiter state encoding, AXIS bundle structs and the round-robin step helper.
package egress_switch_pkg;

  localparam int NUM_INGRESS_PORTS = 4;
  localparam int DEF_NUM_PORTS     = NUM_INGRESS_PORTS;
  localparam int DEF_DATA_W        = 16;
  localparam int DEF_DEST_W        = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] tdata;
    logic [DEF_DEST_W-1:0] tdest;
    logic                  tlast;
    logic                  tvalid;
  } axis_d_src_t;

  typedef struct packed {
    logic tready;
  } axis_d_snk_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/egress_switch_if.sv
// Ingress/egress AXIS bundle of the egress switch; master is the traffic side
// (filter + MAC), slave is the switch itself.
interface egress_switch_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 16,
  parameter int DEST_W    = 2
);
  // Valid/ready: a beat moves on a rising edge where tvalid && tready; the
  // source holds tdata/tdest/tlast stable while tvalid is high and unaccepted.
  logic [NUM_PORTS-1:0][DATA_W-1:0] in_tdata;
  logic [NUM_PORTS-1:0][DEST_W-1:0] in_tdest;
  logic [NUM_PORTS-1:0]             in_tlast;
  logic [NUM_PORTS-1:0]             in_tvalid;
  logic [NUM_PORTS-1:0]             in_tready;
  logic [NUM_PORTS-1:0][DATA_W-1:0] out_tdata;
  logic [NUM_PORTS-1:0]             out_tlast;
  logic [NUM_PORTS-1:0]             out_tvalid;
  logic [NUM_PORTS-1:0]             out_tready;

  modport master (
    output in_tdata, in_tdest, in_tlast, in_tvalid, out_tready,
    input  in_tready, out_tdata, out_tlast, out_tvalid
  );

  modport slave (
    input  in_tdata, in_tdest, in_tlast, in_tvalid, out_tready,
    output in_tready, out_tdata, out_tlast, out_tvalid
  );
endinterface

// File: rtl/egress_switch_arbiter.sv
// One output of the egress switch: request decode, cyclic round-robin pick,
// IDLE/BUSY packet lock and the combinational beat mux from the granted input.
module egress_switch_arbiter
  import egress_switch_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEST_W    = DEF_DEST_W,
  parameter int OUT_IDX   = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             out_en,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] in_tdata,
  input  logic [NUM_PORTS-1:0][DEST_W-1:0] in_tdest,
  input  logic [NUM_PORTS-1:0]             in_tlast,
  input  logic [NUM_PORTS-1:0]             in_tvalid,
  input  logic [NUM_PORTS-1:0]             locked,
  input  logic                             out_tready,
  output logic [DATA_W-1:0]                out_tdata,
  output logic                             out_tlast,
  output logic                             out_tvalid,
  output logic [NUM_PORTS-1:0]             in_tready_part,
  output logic [NUM_PORTS-1:0]             lock_mask,
  output logic                             pkt_done,
  output arb_state_t                       state_dbg
);

  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_t           state, state_nx;
  logic [GW-1:0]        grant, grant_nx;
  logic [GW-1:0]        rr_ptr, rr_ptr_nx;
  logic [NUM_PORTS-1:0] req;
  logic                 found;
  logic [GW-1:0]        pick;
  logic [GW-1:0]        cand;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      rr_ptr <= rr_ptr_nx;
    end
  end

  // Inputs already locked by another output are invisible here, so a tdest
  // change mid-packet can never produce a second grant for the same input.
  always_comb begin : next_state
    state_nx  = state;
    grant_nx  = grant;
    rr_ptr_nx = rr_ptr;
    req       = '0;
    found     = 1'b0;
    pick      = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[i] = in_tvalid[i] && !locked[i] && (int'(in_tdest[i]) == OUT_IDX);
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = GW'((int'(rr_ptr) + k) % NUM_PORTS);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    case (state)
      IDLE: begin
        if (out_en && found) begin
          state_nx = BUSY;
          grant_nx = pick;
        end
      end
      BUSY: begin
        if (pkt_done) begin
          state_nx  = IDLE;
          rr_ptr_nx = GW'(rr_next(int'(grant), NUM_PORTS));
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin : beat_mux
    out_tvalid     = 1'b0;
    out_tdata      = '0;
    out_tlast      = 1'b0;
    in_tready_part = '0;
    lock_mask      = '0;
    if (state == BUSY) begin
      out_tvalid            = in_tvalid[grant];
      out_tdata             = in_tdata[grant];
      out_tlast             = in_tlast[grant];
      in_tready_part[grant] = out_tready;
      lock_mask[grant]      = 1'b1;
    end
    pkt_done = out_tvalid && out_tready && out_tlast;
  end

  assign state_dbg = state;

endmodule

// File: rtl/egress_switch.sv
// Packet-atomic tdest switch, one round-robin arbiter per output.
// Optional per-output packet counters under EGRESS_SWITCH_PKT_COUNT_EN.
module egress_switch
  import egress_switch_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEST_W    = DEF_DEST_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            out_en,
  egress_switch_if.slave                  bus,
  output arb_state_t [NUM_PORTS-1:0]      dbg_state
`ifdef EGRESS_SWITCH_PKT_COUNT_EN
  ,
  output logic [NUM_PORTS-1:0][31:0]      out_pkt_count
`endif
);

  logic [NUM_PORTS-1:0] rdy_part  [NUM_PORTS];
  logic [NUM_PORTS-1:0] lock_part [NUM_PORTS];
  logic [DATA_W-1:0]    o_data    [NUM_PORTS];
  logic [NUM_PORTS-1:0] o_last;
  logic [NUM_PORTS-1:0] o_valid;
  logic [NUM_PORTS-1:0] pkt_done;
  logic [NUM_PORTS-1:0] locked;
  arb_state_t           st        [NUM_PORTS];

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    egress_switch_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .DATA_W    (DATA_W),
      .DEST_W    (DEST_W),
      .OUT_IDX   (o)
    ) u_arb (
      .clk            (clk),
      .reset          (reset),
      .out_en         (out_en[o]),
      .in_tdata       (bus.in_tdata),
      .in_tdest       (bus.in_tdest),
      .in_tlast       (bus.in_tlast),
      .in_tvalid      (bus.in_tvalid),
      .locked         (locked),
      .out_tready     (bus.out_tready[o]),
      .out_tdata      (o_data[o]),
      .out_tlast      (o_last[o]),
      .out_tvalid     (o_valid[o]),
      .in_tready_part (rdy_part[o]),
      .lock_mask      (lock_part[o]),
      .pkt_done       (pkt_done[o]),
      .state_dbg      (st[o])
    );
  end

  always_comb begin : lock_or
    locked = '0;
    for (int o = 0; o < NUM_PORTS; o++) locked = locked | lock_part[o];
  end

  // Each input is granted by at most one output, so OR-ing is a clean merge.
  always_comb begin : ready_or
    bus.in_tready = '0;
    for (int o = 0; o < NUM_PORTS; o++) bus.in_tready = bus.in_tready | rdy_part[o];
  end

  always_comb begin : out_pack
    bus.out_tdata  = '0;
    bus.out_tlast  = o_last;
    bus.out_tvalid = o_valid;
    dbg_state      = '{default: IDLE};
    for (int o = 0; o < NUM_PORTS; o++) begin
      bus.out_tdata[o] = o_data[o];
      dbg_state[o]     = st[o];
    end
  end

`ifdef EGRESS_SWITCH_PKT_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      out_pkt_count <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (pkt_done[o]) out_pkt_count[o] <= out_pkt_count[o] + 32'd1;
      end
    end
  end
`else
  logic pkt_done_unused;
  assign pkt_done_unused = ^pkt_done;
`endif

endmodule

// File: tb/tb_egress_switch.sv
// Directed + random bench for egress_switch; packet-level scoreboard keyed by
// (source, destination), source index carried in tdata[15:14].
module tb_egress_switch;
  import egress_switch_pkg::*;

  localparam int NP = 4;
  localparam int DW = 16;
  localparam int TW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] dest;
    logic          last;
  } beat_t;

  logic                  clk    = 1'b0;
  logic                  reset  = 1'b1;
  logic [NP-1:0]         out_en = '1;
  arb_state_t [NP-1:0]   dbg_state;
`ifdef EGRESS_SWITCH_PKT_COUNT_EN
  logic [NP-1:0][31:0]   out_pkt_count;
`endif

  egress_switch_if #(.NUM_PORTS(NP), .DATA_W(DW), .DEST_W(TW)) bus ();

  egress_switch #(.NUM_PORTS(NP), .DATA_W(DW), .DEST_W(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .out_en    (out_en),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef EGRESS_SWITCH_PKT_COUNT_EN
    ,
    .out_pkt_count (out_pkt_count)
`endif
  );

  // ---- clock / watchdog ----
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish by 400us, required finish");
    $fatal(1, "watchdog expired");
  end

  // ---- bench state ----
  beat_t       drv_q [NP][$];
  logic [16:0] exp_q [NP][NP][$];
  int          src_log [NP][$];
  int          gap_log [NP][$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          seq      [NP];
  bit          in_pkt   [NP];
  int          cur_src  [NP];
  int          last_end [NP];
  int          first_cyc[NP];
  int          beats    [NP];
  int          model_cnt[NP];
  logic [NP-1:0] rdy_val    = '1;
  logic [NP-1:0] watch_idle = '0;
  bit            rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---- driver ----
  function automatic logic [DW-1:0] mk_base(input int src);
    logic [1:0] s;
    s = 2'(src);
    mk_base = {s, 14'(seq[src])};
    seq[src] += 8;
  endfunction

  task automatic send_pkt(input int src, input int dest, input int len,
                          input logic [DW-1:0] base, input int dest_after);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = DW'(base + DW'(k));
      b.dest = (k > 0 && dest_after >= 0) ? TW'(dest_after) : TW'(dest);
      b.last = (k == len - 1);
      drv_q[src].push_back(b);
      exp_q[src][dest].push_back({b.last, b.data});
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NP; i++) begin
      if (drv_q[i].size() > 0) begin
        bus.in_tvalid[i] = 1'b1;
        bus.in_tdata[i]  = drv_q[i][0].data;
        bus.in_tdest[i]  = drv_q[i][0].dest;
        bus.in_tlast[i]  = drv_q[i][0].last;
      end else begin
        bus.in_tvalid[i] = 1'b0;
        bus.in_tdata[i]  = '0;
        bus.in_tdest[i]  = '0;
        bus.in_tlast[i]  = 1'b0;
      end
    end
    for (int o = 0; o < NP; o++)
      bus.out_tready[o] = rand_ready ? ($urandom_range(0, 3) != 0) : rdy_val[o];
  endtask

  task automatic flush();
    for (int i = 0; i < NP; i++) begin
      drv_q[i].delete();
      for (int o = 0; o < NP; o++) exp_q[i][o].delete();
      in_pkt[i]   = 1'b0;
      last_end[i] = -1;
      model_cnt[i] = 0;
    end
  endtask

  // ---- scoreboard (sampled at negedge) ----
  task automatic monitor();
    logic [16:0] beat;
    for (int o = 0; o < NP; o++) begin
      if (watch_idle[o]) chk($sformatf("idle_out%0d", o), 32'(bus.out_tvalid[o]), 0);
      if (bus.out_tvalid[o] && bus.out_tready[o]) begin
        beat = {bus.out_tlast[o], bus.out_tdata[o]};
        if (!in_pkt[o]) begin
          cur_src[o]   = int'(bus.out_tdata[o][15:14]);
          in_pkt[o]    = 1'b1;
          first_cyc[o] = cyc;
          src_log[o].push_back(cur_src[o]);
          if (last_end[o] >= 0) begin
            gap_log[o].push_back(cyc - last_end[o]);
            chk($sformatf("pkt_gap_out%0d", o), 32'(cyc - last_end[o] >= 2), 1);
          end
        end
        chk($sformatf("beat_expected_out%0d", o), 32'(exp_q[cur_src[o]][o].size() > 0), 1);
        if (exp_q[cur_src[o]][o].size() > 0) begin
          chk($sformatf("beat_out%0d", o), 32'(beat), 32'(exp_q[cur_src[o]][o][0]));
          void'(exp_q[cur_src[o]][o].pop_front());
        end
        beats[o]++;
        if (bus.out_tlast[o]) begin
          in_pkt[o]   = 1'b0;
          last_end[o] = cyc;
          model_cnt[o]++;
        end
      end
    end
  endtask

  task automatic step();
    logic [NP-1:0] hs;
    @(negedge clk);
    monitor();
    hs = bus.in_tvalid & bus.in_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) if (hs[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
    drive_inputs();
    #1;
    cyc++;
  endtask

  function automatic bit pending();
    for (int i = 0; i < NP; i++) begin
      if (drv_q[i].size() != 0 || in_pkt[i]) return 1'b1;
      for (int o = 0; o < NP; o++) if (exp_q[i][o].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 32'(pending()), 0);
    step();
    step();
  endtask

`ifdef EGRESS_SWITCH_PKT_COUNT_EN
  task automatic chk_counts(input string tag);
    for (int o = 0; o < NP; o++)
      chk($sformatf("%s_cnt%0d", tag, o), out_pkt_count[o], 32'(model_cnt[o]));
  endtask
`endif

  // ---- directed + random sequence ----
  initial begin
    int c0, b0, b1, b3, acc, n;
    int pat [5] = '{1, 0, 0, 1, 1};
    logic [DW-1:0] base;

    for (int i = 0; i < NP; i++) begin
      seq[i] = 0; in_pkt[i] = 0; cur_src[i] = 0; last_end[i] = -1;
      first_cyc[i] = 0; beats[i] = 0; model_cnt[i] = 0;
    end

    // Reset: a valid beat is presented, nothing may be accepted or forwarded
    send_pkt(0, 0, 2, 16'h00aa, -1);
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_tready", 32'(bus.in_tready), 0);
    for (int o = 0; o < NP; o++) begin
      chk($sformatf("rst_out_tvalid%0d", o), 32'(bus.out_tvalid[o]), 0);
      chk($sformatf("rst_out_tlast%0d", o), 32'(bus.out_tlast[o]), 0);
      chk($sformatf("rst_out_tdata%0d", o), 32'(bus.out_tdata[o]), 0);
      chk($sformatf("rst_state%0d", o), 32'(dbg_state[o]), 32'(IDLE));
    end
`ifdef EGRESS_SWITCH_PKT_COUNT_EN
    chk_counts("rst");
`endif
    flush();
    drive_inputs();
    reset = 1'b0;
    step();

    // T1: input0 4-beat packet to out2, one decision cycle of latency
    b0 = beats[0]; b1 = beats[1]; b3 = beats[3];
    send_pkt(0, 2, 4, 16'h0001, -1);
    drive_inputs();
    #1;
    c0 = cyc;
    chk("t1_decide_tvalid", 32'(bus.out_tvalid), 0);
    chk("t1_decide_tready0", 32'(bus.in_tready[0]), 0);
    step();
    chk("t1_first_tvalid", 32'(bus.out_tvalid[2]), 1);
    chk("t1_first_tdata", 32'(bus.out_tdata[2]), 32'h0001);
    chk("t1_first_tready0", 32'(bus.in_tready[0]), 1);
    chk("t1_state_busy", 32'(dbg_state[2]), 32'(BUSY));
    drain("t1", 40);
    chk("t1_latency", 32'(first_cyc[2]), 32'(c0 + 1));
    chk("t1_out0_idle", 32'(beats[0] - b0), 0);
    chk("t1_out1_idle", 32'(beats[1] - b1), 0);
    chk("t1_out3_idle", 32'(beats[3] - b3), 0);

    // T2: inputs 0,1,3 contend for out1, twice
    for (int r = 0; r < 2; r++) begin
      src_log[1].delete();
      gap_log[1].delete();
      send_pkt(0, 1, 2, mk_base(0), -1);
      send_pkt(1, 1, 2, mk_base(1), -1);
      send_pkt(3, 1, 2, mk_base(3), -1);
      drive_inputs();
      drain($sformatf("t2r%0d", r), 60);
      chk($sformatf("t2r%0d_npkts", r), 32'(src_log[1].size()), 3);
      if (src_log[1].size() == 3) begin
        chk($sformatf("t2r%0d_order0", r), 32'(src_log[1][0]), 0);
        chk($sformatf("t2r%0d_order1", r), 32'(src_log[1][1]), 1);
        chk($sformatf("t2r%0d_order2", r), 32'(src_log[1][2]), 3);
      end
      for (int g = r; g < gap_log[1].size(); g++)
        chk($sformatf("t2r%0d_gap%0d", r, g), 32'(gap_log[1][g]), 2);
    end

    // T3: backpressure on out0 with input2 3-beat packet
    base = mk_base(2);
    send_pkt(2, 0, 3, base, -1);
    drive_inputs();
    step();
    acc = 0;
    for (int p = 0; p < 5; p++) begin
      rdy_val[0] = pat[p][0];
      drive_inputs();
      #1;
      chk($sformatf("t3_tvalid_c%0d", p), 32'(bus.out_tvalid[0]), 1);
      chk($sformatf("t3_tdata_c%0d", p), 32'(bus.out_tdata[0]), 32'(base + DW'(acc)));
      chk($sformatf("t3_tlast_c%0d", p), 32'(bus.out_tlast[0]), 32'(acc == 2));
      chk($sformatf("t3_tready_c%0d", p), 32'(bus.in_tready[2]), 32'(pat[p]));
      step();
      if (pat[p] != 0) acc++;
    end
    chk("t3_all_sent", 32'(drv_q[2].size()), 0);
    rdy_val = '1;
    drain("t3", 20);

    // T4: tdest changes mid-packet, packet stays on out0
    b0 = beats[0]; b3 = beats[3];
    watch_idle[3] = 1'b1;
    send_pkt(1, 0, 3, mk_base(1), 3);
    drive_inputs();
    drain("t4", 30);
    watch_idle = '0;
    chk("t4_out0_beats", 32'(beats[0] - b0), 3);
    chk("t4_out3_beats", 32'(beats[3] - b3), 0);

    // T5: out_en[3] dropped mid-packet
    send_pkt(0, 3, 4, mk_base(0), -1);
    send_pkt(1, 3, 2, mk_base(1), -1);
    drive_inputs();
    step();
    out_en[3] = 1'b0;
    n = 0;
    while (drv_q[0].size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("t5_first_done", 32'(drv_q[0].size()), 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("t5_blocked_tready_c%0d", k), 32'(bus.in_tready[1]), 0);
      chk($sformatf("t5_blocked_tvalid_c%0d", k), 32'(bus.out_tvalid[3]), 0);
    end
    out_en[3] = 1'b1;
    drain("t5", 30);
    chk("t5_second_src", 32'(src_log[3][src_log[3].size() - 1]), 1);

    // T6: reset mid-packet, then counted single-beat packets
    send_pkt(2, 1, 6, mk_base(2), -1);
    drive_inputs();
    step();
    step();
    step();
    reset = 1'b1;
    step();
    chk("t6_rst_tready", 32'(bus.in_tready), 0);
    chk("t6_rst_tvalid", 32'(bus.out_tvalid), 0);
    chk("t6_rst_tdata1", 32'(bus.out_tdata[1]), 0);
    chk("t6_rst_state1", 32'(dbg_state[1]), 32'(IDLE));
    flush();
`ifdef EGRESS_SWITCH_PKT_COUNT_EN
    chk_counts("t6_rst");
`endif
    reset = 1'b0;
    drive_inputs();
    step();
    for (int k = 0; k < 5; k++) send_pkt(3, 0, 1, mk_base(3), -1);
    drive_inputs();
    drain("t6", 40);
    chk("t6_model_cnt0", 32'(model_cnt[0]), 5);
`ifdef EGRESS_SWITCH_PKT_COUNT_EN
    chk("t6_pkt_count0", out_pkt_count[0], 32'd5);
`endif

    // Random traffic with random downstream ready
    rand_ready = 1'b1;
    for (int k = 0; k < 150; k++) begin
      int s, d, len, da;
      s   = $urandom_range(0, NP - 1);
      d   = $urandom_range(0, NP - 1);
      len = $urandom_range(1, 5);
      da  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NP - 1)) : -1;
      send_pkt(s, d, len, mk_base(s), da);
    end
    drive_inputs();
    drain("rand", 5000);
    rand_ready = 1'b0;
    drive_inputs();
`ifdef EGRESS_SWITCH_PKT_COUNT_EN
    chk_counts("rand");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
